// File: rtl/decoder_rr_arbiter_pkg.sv
// decoder_rr_arbiter_pkg: shared widths, state encodings and round-robin pick for decoder_rr_arbiter
package decoder_rr_arbiter_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  // Rotate req so ptr sits at bit 0, take the lowest set bit, then un-rotate by adding ptr back (wraps mod 8).
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req, input logic [IDX_W-1:0] ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [IDX_W-1:0] off;
    dbl = {req, req} >> ptr;
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (dbl[i]) off = IDX_W'(i);
    return off + ptr;
  endfunction
endpackage

// File: rtl/decoder_rr_arbiter_decoder38.sv
// decoder38: 3-to-8 one-hot decoder; a is the MSB of the code {a,b,c}, y[{a,b,c}] is the only set bit
module decoder38 (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic [7:0] y
);
  assign y = 8'd1 << {a, b, c};
endmodule

// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: round-robin sharing of one decoder38 between 8 requesters, grants capped at MAX_HOLD cycles
//   clk, rst_n (async, active-low) | req[7:0] level requests
//   grant_valid, grant_idx[2:0], grant_onehot[7:0] (decoder output, gated) | preempt pulse | busy
module decoder_rr_arbiter
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant_onehot,
  output logic             preempt,
  output logic             busy
);
  logic [1:0] st;
  logic [HOLD_W-1:0] hold;
  logic [IDX_W-1:0] ptr;
  logic [N_REQ-1:0] y;
  logic expire;
  assign expire = hold == HOLD_W'(MAX_HOLD - 1);
  decoder38 u_dec (.a(grant_idx[2]), .b(grant_idx[1]), .c(grant_idx[0]), .y(y));
  assign grant_valid = st == ST_GRANT;
  assign grant_onehot = grant_valid ? y : '0;
  assign busy = st != ST_IDLE;
  // grant_idx is cleared on release so it reads 0 whenever no grant is active.
  // IDLE and RELEASE share the arbitration path; any unused encoding falls back to it as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= ST_IDLE;
      grant_idx <= '0;
      hold <= '0;
      ptr <= '0;
      preempt <= 1'b0;
    end else begin
      preempt <= 1'b0;
      if (st == ST_GRANT) begin
        if (!req[grant_idx] || expire) begin
          st <= ST_RELEASE;
          ptr <= grant_idx + 1'b1;
          grant_idx <= '0;
          preempt <= req[grant_idx];
        end else begin
          hold <= hold + 1'b1;
        end
      end else if (|req) begin
        st <= ST_GRANT;
        grant_idx <= rr_pick(req, ptr);
        hold <= '0;
      end else begin
        st <= ST_IDLE;
      end
    end
  end
endmodule
